// File: rtl/pipelined_controller.sv
// Control path of the 5-stage RV32I pipeline: D-stage decode, E/M/W control registers,
// Execute-stage branch resolution and an optional multi-cycle mul/div occupancy sequencer.
module pipelined_controller #(
    parameter int M_EXT      = 1,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opD,
    input  logic [2:0] funct3D,
    input  logic       funct7b5D,
    input  logic       funct7b0D,
    input  logic       FlushE,
    input  logic       ZeroE,
    input  logic       LtE,
    input  logic       LtuE,
    output logic [1:0] ImmSrcD,
    output logic       ALUSrcE,
    output logic [3:0] ALUControlE,
    output logic       JalrE,
    output logic       PCSrcE,
    output logic [1:0] ResultSrcE,
    output logic       RegWriteE,
    output logic       MdValidE,
    output logic [2:0] MdOpE,
    output logic       MdStartE,
    output logic       MdDoneE,
    output logic       MdBusyE,
    output logic       MemWriteM,
    output logic       RegWriteM,
    output logic [1:0] ResultSrcM,
    output logic       RegWriteW,
    output logic [1:0] ResultSrcW
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [3:0] alu_control;
        logic       alu_src;
        logic       jalr;
        logic [2:0] funct3;
        logic       md_valid;
        logic [2:0] md_op;
    } ctrl_e_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
    } ctrl_m_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
    } ctrl_w_t;

    ctrl_e_t    dec_ctrl;
    logic [1:0] dec_imm_src;
    logic [1:0] dec_alu_op;
    logic       dec_md_sel;

    ctrl_e_t e_q, e_d;
    ctrl_m_t m_q, m_d;
    ctrl_w_t w_q;

    logic md_busy, md_start, md_done;
    logic br_taken;

    // Main decode followed by ALU decode; M ops reuse the R-type bundle but are flagged.
    always_comb begin
        dec_ctrl    = '0;
        dec_imm_src = 2'b00;
        dec_alu_op  = 2'b00;
        dec_md_sel  = (M_EXT != 0) && (opD == 7'b0110011) && funct7b0D;
        case (opD)
            7'b0000011: begin
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.result_src = 2'b01;
            end
            7'b0100011: begin
                dec_imm_src        = 2'b01;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.mem_write = 1'b1;
            end
            7'b0110011: begin
                dec_ctrl.reg_write = 1'b1;
                dec_alu_op         = 2'b10;
            end
            7'b1100011: begin
                dec_imm_src     = 2'b10;
                dec_ctrl.branch = 1'b1;
                dec_alu_op      = 2'b01;
            end
            7'b0010011: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_alu_op         = 2'b10;
            end
            7'b1101111: begin
                dec_ctrl.reg_write  = 1'b1;
                dec_imm_src         = 2'b11;
                dec_ctrl.result_src = 2'b10;
                dec_ctrl.jump       = 1'b1;
            end
            7'b1100111: begin
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.result_src = 2'b10;
                dec_ctrl.jump       = 1'b1;
                dec_ctrl.jalr       = 1'b1;
            end
            default: ;
        endcase

        case (dec_alu_op)
            2'b00:   dec_ctrl.alu_control = ALU_ADD;
            2'b01:   dec_ctrl.alu_control = ALU_SUB;
            default: begin
                case (funct3D)
                    3'b000:  dec_ctrl.alu_control = (opD[5] & funct7b5D) ? ALU_SUB : ALU_ADD;
                    3'b001:  dec_ctrl.alu_control = ALU_SLL;
                    3'b010:  dec_ctrl.alu_control = ALU_SLT;
                    3'b011:  dec_ctrl.alu_control = ALU_SLTU;
                    3'b100:  dec_ctrl.alu_control = ALU_XOR;
                    3'b101:  dec_ctrl.alu_control = funct7b5D ? ALU_SRA : ALU_SRL;
                    3'b110:  dec_ctrl.alu_control = ALU_OR;
                    default: dec_ctrl.alu_control = ALU_AND;
                endcase
            end
        endcase

        dec_ctrl.funct3 = funct3D;
        if (dec_md_sel) begin
            dec_ctrl.md_valid    = 1'b1;
            dec_ctrl.md_op       = funct3D;
            dec_ctrl.alu_control = ALU_ADD;
        end
    end

    assign ImmSrcD = dec_imm_src;

    // A running M op holds E in place; any flush arriving meanwhile is dropped.
    always_comb begin
        if (md_busy)     e_d = e_q;
        else if (FlushE) e_d = '0;
        else             e_d = dec_ctrl;
    end

    always_comb begin
        m_d = '0;
        if (!md_busy) begin
            m_d.reg_write  = e_q.reg_write;
            m_d.result_src = e_q.result_src;
            m_d.mem_write  = e_q.mem_write;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q.reg_write  <= m_q.reg_write;
            w_q.result_src <= m_q.result_src;
        end
    end

    always_comb begin
        case (e_q.funct3)
            3'b000:  br_taken = ZeroE;
            3'b001:  br_taken = !ZeroE;
            3'b100:  br_taken = LtE;
            3'b101:  br_taken = !LtE;
            3'b110:  br_taken = LtuE;
            3'b111:  br_taken = !LtuE;
            default: br_taken = 1'b0;
        endcase
    end

    assign PCSrcE = (e_q.branch & br_taken) | e_q.jump;

    generate
        if (M_EXT != 0) begin : g_md
            typedef enum logic {S_IDLE, S_BUSY} state_t;
            state_t        state_q, state_d;
            logic [CW-1:0] cnt_q, cnt_d;
            logic [CW-1:0] lat;

            assign lat = e_q.md_op[2] ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                end
            end

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                case (state_q)
                    S_IDLE: begin
                        if (e_q.md_valid && (lat != CW'(1))) begin
                            state_d = S_BUSY;
                            cnt_d   = CW'(1);
                        end
                    end
                    default: begin
                        if (cnt_q < lat - CW'(1)) begin
                            cnt_d = cnt_q + CW'(1);
                        end else begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end
                    end
                endcase
            end

            always_comb begin
                md_start = 1'b0;
                md_busy  = 1'b0;
                md_done  = 1'b0;
                case (state_q)
                    S_IDLE: begin
                        if (e_q.md_valid) begin
                            md_start = 1'b1;
                            if (lat == CW'(1)) md_done = 1'b1;
                            else               md_busy = 1'b1;
                        end
                    end
                    default: begin
                        if (cnt_q < lat - CW'(1)) md_busy = 1'b1;
                        else                      md_done = 1'b1;
                    end
                endcase
            end
        end else begin : g_no_md
            assign md_start = 1'b0;
            assign md_busy  = 1'b0;
            assign md_done  = 1'b0;
        end
    endgenerate

    assign ALUSrcE     = e_q.alu_src;
    assign ALUControlE = e_q.alu_control;
    assign JalrE       = e_q.jalr;
    assign ResultSrcE  = e_q.result_src;
    assign RegWriteE   = e_q.reg_write;
    assign MdValidE    = e_q.md_valid;
    assign MdOpE       = e_q.md_op;
    assign MdStartE    = md_start;
    assign MdDoneE     = md_done;
    assign MdBusyE     = md_busy;
    assign MemWriteM   = m_q.mem_write;
    assign RegWriteM   = m_q.reg_write;
    assign ResultSrcM  = m_q.result_src;
    assign RegWriteW   = w_q.reg_write;
    assign ResultSrcW  = w_q.result_src;

endmodule

// File: doc/pipelined_controller.md
Name: pipelined_controller

Overview:
Pipelined control unit for the 5-stage RV32I CPU. Decodes the instruction in the Decode stage and carries its control bundle through the E, M and W pipeline registers, with bubble insertion on flush. Resolves branches in the Execute stage for all six RV32I branch conditions. When M_EXT=1, a multi-cycle mul/div sequencer holds the Execute stage for a fixed per-class latency and raises a stall request to the hazard unit.

Parameters:
M_EXT, 1, 1 = decode RV32M ops (op=0110011, funct7=0000001) and run the mul/div sequencer; 0 = sequencer removed, MdBusyE tied 0.
MUL_CYCLES, 2, Execute-stage occupancy in cycles for mul/mulh/mulhsu/mulhu (funct3[2]=0); minimum 1.
DIV_CYCLES, 33, Execute-stage occupancy in cycles for div/divu/rem/remu (funct3[2]=1); minimum 1.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
opD  in  7  opcode of the instruction in D
funct3D  in  3  funct3 of the instruction in D
funct7b5D  in  1  instr[30]
funct7b0D  in  1  instr[25]; identifies M ops
FlushE  in  1  hazard unit: load a bubble into E
ZeroE  in  1  ALU result == 0
LtE  in  1  signed SrcA < SrcB
LtuE  in  1  unsigned SrcA < SrcB
ImmSrcD  out  2  immediate-extend select, combinational from D
ALUSrcE  out  1  ALU B-operand select
ALUControlE  out  4  ALU operation; same encoding as the existing RV32I ALU decode
JalrE  out  1  jalr in E
PCSrcE  out  1  redirect PC (taken branch or jump)
ResultSrcE  out  2  for load-use detection
RegWriteE  out  1  for hazard detection
MdValidE  out  1  M op occupying E
MdOpE  out  3  funct3 of the M op in E
MdStartE  out  1  one-cycle pulse on the first E cycle of an M op
MdDoneE  out  1  last E cycle of an M op; result valid
MdBusyE  out  1  stall request: hazard unit must hold F/D and leave E unflushed
MemWriteM  out  1  data memory write enable
RegWriteM  out  1  register-file write in M
ResultSrcM  out  2  forwarding mux select
RegWriteW  out  1  register-file write enable
ResultSrcW  out  2  writeback mux select

Behaviour:
- D decode is purely combinational (main decode plus ALU decode). With M_EXT=0, funct7b0D is ignored and M opcodes decode as ordinary R-type.
- E register priority: reset > MdBusyE (hold) > FlushE (bubble) > load from D.
  - Bubble = all control bits 0, including MdValidE.
  - FlushE is ignored while MdBusyE=1.
- M register: loads a bubble when reset or MdBusyE=1; otherwise loads E.
- W register: loads M every cycle; cleared on reset.
- Reset value of every registered output is 0.
- Branch taken condition by funct3E:
  - 000: ZeroE
  - 001: !ZeroE
  - 100: LtE
  - 101: !LtE
  - 110: LtuE
  - 111: !LtuE
  - 010/011: not taken
- PCSrcE = (BranchE & taken) | JumpE. It is combinational and is 0 for bubbles.
- Sequencer (M_EXT=1):
  - States: IDLE, BUSY. Counter cnt has width clog2(max(MUL_CYCLES,DIV_CYCLES)+1).
  - LAT = DIV_CYCLES if MdOpE[2]=1, else MUL_CYCLES.
  - IDLE, MdValidE=1:
    - MdStartE=1.
    - If LAT=1: MdDoneE=1, MdBusyE=0, stay IDLE.
    - Else: MdBusyE=1, next state BUSY, cnt<=1.
  - BUSY:
    - If cnt<LAT-1: MdBusyE=1, cnt<=cnt+1.
    - If cnt==LAT-1: MdBusyE=0, MdDoneE=1, next state IDLE, cnt<=0.
  - An M op therefore occupies E for exactly LAT cycles, with MdBusyE high for LAT-1 of them.
  - Back-to-back M ops: the second op enters E the cycle after MdDoneE and restarts from IDLE with a fresh MdStartE.
- Reset mid-operation: FSM returns to IDLE, cnt=0, all pipeline registers are bubbled, and MdBusyE falls on the cycle after reset is sampled.
- Non-M ops never assert any Md* output.

Test Plan:
- Reset: hold reset 2 cycles with an add in D -> every output 0; after release, add (0110011/000/0) reaches W in 3 cycles with RegWriteW=1, ResultSrcW=00.
- Branches: beq with ZeroE=1 -> PCSrcE=1; bne with ZeroE=1 -> 0; blt with LtE=1 -> 1; bgeu with LtuE=1 -> 0; funct3=010 -> 0; jal -> PCSrcE=1 regardless of flags.
- Flush: lw in D with FlushE=1 -> next cycle RegWriteE=0 and ResultSrcE=00; the following instruction is unaffected.
- Mul, MUL_CYCLES=2: mul enters E -> MdStartE=1 and MdBusyE=1 on cycle 0; cycle 1 MdBusyE=0 and MdDoneE=1; M receives a bubble on cycle 0 and the mul on cycle 1.
- Div, DIV_CYCLES=33, with FlushE pulsed mid-op: MdBusyE high for exactly 32 cycles, then MdDoneE=1; the flush has no effect; a back-to-back divu gets a fresh 33-cycle occupancy.
- Reset asserted at cycle 10 of a div -> FSM returns to IDLE, MdBusyE=0 and MdValidE=0 the next cycle. M_EXT=0 build: mul decodes as add-class R-type with MdBusyE=0 throughout.
